wb_master_arb: RTL
==================

Name: wb_master_arb

Overview:
- Round-robin WISHBONE master arbiter with a bus watchdog, for the shared interconnect behind the 8 master ports.
- Decides which master owns the slave side and holds ownership for the master's whole cycle.
- Terminates transfers that stall with an error response.
- Provides a saturating stall-event counter for software diagnostics through the perf block.

Parameters:
- NMASTERS, 8, number of requesting masters; 2..8 supported.
- TIMEOUT, 255, consecutive stalled strobe cycles before abort; 2..65535.
- HIPRI_MASK, 8'h03, masters in this class (CPU iwb/dwb) win over all others.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- cyc_i  in  NMASTERS  per-master cycle request.
- stb_i  in  NMASTERS  per-master strobe.
- ack_i  in  1  ack from the selected slave.
- err_i  in  1  err from the selected slave.
- gnt_o  out  NMASTERS  one-hot grant; all-zero when idle.
- gnt_idx_o  out  3  binary index of the granted master.
- gnt_valid_o  out  1  a grant is active.
- to_err_o  out  NMASTERS  one-cycle watchdog error to the granted master.
- to_cnt_o  out  16  saturating count of watchdog aborts.
- to_cnt_clr_i  in  1  synchronous clear of to_cnt_o.

Behaviour:
- Reset state (rst_i sampled high at a clk_i edge):
  - FSM enters IDLE.
  - gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, to_err_o=0, to_cnt_o=0.
  - Round-robin pointer last=NMASTERS-1.
  - Watchdog counter wd=0.
- Reset asserted mid-grant drops the grant on that edge; no to_err_o is issued.
- FSM states: IDLE, GRANT, ABORT.
- IDLE:
  - If no cyc_i bit is set, stay in IDLE.
  - Otherwise choose a winner and register gnt_o, gnt_idx_o, gnt_valid_o=1, then move to GRANT. Grant is visible one cycle after cyc_i is first sampled.
  - Winner selection:
    - If any requester is in HIPRI_MASK, search only HIPRI requesters; otherwise search all requesters.
    - Search order is last+1, last+2, ... modulo NMASTERS; the first match wins.
    - last <= winner.
- GRANT:
  - Grant is held while cyc_i[gnt_idx_o]=1. Other requests are ignored; there is no preemption.
  - When cyc_i[gnt_idx_o]=0 is sampled, clear gnt_o and gnt_valid_o at that edge and go to IDLE.
  - There is exactly one idle cycle between consecutive owners, even if others are requesting.
- Watchdog (GRANT only):
  - stall = stb_i[g] & cyc_i[g] & ~ack_i & ~err_i, where g = gnt_idx_o.
  - stall=1: wd <= wd+1. Otherwise wd <= 0.
  - When stall=1 and wd==TIMEOUT-1, go to ABORT. wd is 16 bits and never wraps, because ABORT clears it.
  - ack_i or err_i arriving in the same cycle that wd reaches TIMEOUT-1 means stall=0, so no abort occurs.
- ABORT (exactly one cycle):
  - to_err_o[g]=1 (registered, asserted during the ABORT cycle only).
  - wd <= 0.
  - to_cnt_o <= to_cnt_o+1, saturating at 16'hFFFF.
  - Grant is kept; the next state is GRANT.
  - If the master drops cyc_i during ABORT, the GRANT state releases on the following cycle.
- to_cnt_clr_i:
  - Clears to_cnt_o at the edge.
  - If it coincides with an ABORT increment, the clear wins (result 0).
- Requests with cyc_i=1 and stb_i=0 hold the grant indefinitely with no timeout. This is legal for lock/RMW.
- gnt_idx_o always equals the encoding of gnt_o while gnt_valid_o=1. It holds its last value while idle.
- Bits of cyc_i/stb_i at index >= NMASTERS do not exist. gnt_idx_o width is fixed at 3.

Test Plan:
- Reset then cyc_i=8'h10 held 3 cycles, stb/ack each cycle -> gnt_o=8'h10, gnt_idx_o=4 one cycle after request; released the cycle after cyc drops; to_err_o stays 0.
- cyc_i=8'hF0 constant, each master drops cyc after 2 cycles, re-requesting after 1 idle -> grant order 4,5,6,7,4,... with exactly one idle cycle between grants.
- cyc_i=8'h84 (masters 2 and 7), then cyc_i[0] raised while 7 is granted -> 7 completes, then 0 granted before 2 (HIPRI); no preemption of 7.
- TIMEOUT=4, granted master holds stb with no ack -> to_err_o[g]=1 on the 5th cycle after the first stalled cycle; to_cnt_o=1; grant held; ack arriving on the 4th stalled cycle instead -> no abort.
- Force 3 aborts, then pulse to_cnt_clr_i in the same cycle as a 4th ABORT -> to_cnt_o=0.
- Assert rst_i during GRANT with wd=2 -> next cycle gnt_o=0, gnt_valid_o=0, wd=0; first post-reset request from master 0 is granted (pointer reset to 7).

Source files
------------

// File: rtl/wb_master_arb.sv
// ============================================================================
// Module      : wb_master_arb
// Description : Round-robin WISHBONE master arbiter with a high-priority class,
//               per-cycle ownership, a stall watchdog and a saturating
//               abort counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_arb #(
    parameter int         NMASTERS   = 8,
    parameter int         TIMEOUT    = 255,
    parameter logic [7:0] HIPRI_MASK = 8'h03
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NMASTERS-1:0] cyc_i,
    input  logic [NMASTERS-1:0] stb_i,
    input  logic                ack_i,
    input  logic                err_i,
    output logic [NMASTERS-1:0] gnt_o,
    output logic [2:0]          gnt_idx_o,
    output logic                gnt_valid_o,
    output logic [NMASTERS-1:0] to_err_o,
    output logic [15:0]         to_cnt_o,
    input  logic                to_cnt_clr_i
);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_GRANT = 2'd1;
    localparam logic [1:0]  c_ST_ABORT = 2'd2;
    localparam logic [15:0] c_WD_LAST  = 16'(TIMEOUT - 1);
    localparam logic [2:0]  c_LAST_RST = 3'(NMASTERS - 1);
    localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [2:0]          r_last;
    logic [15:0]         r_wd;
    logic [NMASTERS-1:0] r_gnt;
    logic [2:0]          r_gnt_idx;
    logic                r_gnt_valid;
    logic [NMASTERS-1:0] r_to_err;
    logic [15:0]         r_to_cnt;

    logic [7:0]          w_cyc;
    logic [7:0]          w_stb;
    logic [7:0]          w_hi;
    logic [7:0]          w_req;
    logic                w_win_found;
    logic [2:0]          w_win_idx;
    logic [2:0]          w_cand;
    logic [NMASTERS-1:0] w_win_oh;
    logic                w_own;
    logic                w_stall;

    // Widen requests to 8 bits so the 3-bit index can never go out of range.
    always_comb begin
        w_cyc                 = '0;
        w_stb                 = '0;
        w_cyc[NMASTERS-1:0]   = cyc_i;
        w_stb[NMASTERS-1:0]   = stb_i;
        w_hi                  = w_cyc & HIPRI_MASK;
        w_req                 = (|w_hi) ? w_hi : w_cyc;
    end

    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int k = 1; k <= NMASTERS; k++) begin
            w_cand = 3'((int'(r_last) + k) % NMASTERS);
            if (!w_win_found && w_req[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_win_oh = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            w_win_oh[i] = (w_win_idx == 3'(i));
        end
    end

    assign w_own   = w_cyc[r_gnt_idx];
    assign w_stall = w_stb[r_gnt_idx] & w_own & ~ack_i & ~err_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt = c_ST_GRANT;
                end
            end
            c_ST_GRANT: begin
                if (!w_own) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_stall && (r_wd == c_WD_LAST)) begin
                    w_state_nxt = c_ST_ABORT;
                end
            end
            c_ST_ABORT: begin
                w_state_nxt = c_ST_GRANT;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last      <= c_LAST_RST;
            r_wd        <= '0;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_to_err    <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_to_err <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    r_wd <= '0;
                    if (w_win_found) begin
                        r_gnt       <= w_win_oh;
                        r_gnt_idx   <= w_win_idx;
                        r_gnt_valid <= 1'b1;
                        r_last      <= w_win_idx;
                    end
                end
                c_ST_GRANT: begin
                    if (!w_own) begin
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                        r_wd        <= '0;
                    end else if (w_stall) begin
                        r_wd <= r_wd + 16'd1;
                        // Error pulse lands in the ABORT cycle itself.
                        if (r_wd == c_WD_LAST) begin
                            r_to_err <= r_gnt;
                        end
                    end else begin
                        r_wd <= '0;
                    end
                end
                c_ST_ABORT: begin
                    r_wd <= '0;
                end
                default: begin
                    r_wd <= '0;
                end
            endcase

            if (to_cnt_clr_i) begin
                r_to_cnt <= '0;
            end else if ((r_state == c_ST_ABORT) && (r_to_cnt != c_CNT_MAX)) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_idx_o   = r_gnt_idx;
    assign gnt_valid_o = r_gnt_valid;
    assign to_err_o    = r_to_err;
    assign to_cnt_o    = r_to_cnt;

endmodule

`default_nettype wire
